// File: rtl/quad_pkg.sv
// Shared AB state encodings, direction levels and transition helpers for quad_step_decoder.
package quad_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Up sequence is 00->10->11->01->00; only meaningful for one-bit transitions.
  function automatic logic is_up(input logic [1:0] prev, input logic [1:0] curr);
    return ((prev == ST_00) && (curr == ST_10)) ||
           ((prev == ST_10) && (curr == ST_11)) ||
           ((prev == ST_11) && (curr == ST_01)) ||
           ((prev == ST_01) && (curr == ST_00));
  endfunction

  function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] curr);
    return (prev ^ curr) == 2'b11;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter; dout follows the synchronised
// input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_filt;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign dout = r_filt;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder decoder: debounced A/B to step strobe, direction and error count.
// Define QUAD_X4_EN to strobe on every valid edge; default strobes only on entry to AB=00.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  output logic                 step,
  output logic                 up_dn,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ErrCntMax = '1;

  logic                 w_filt_a;
  logic                 w_filt_b;
  logic [1:0]           w_curr_ab;
  logic                 w_step_d;
  logic                 w_err_d;
  logic                 w_up_dn_d;
  logic [1:0]           r_prev_ab;
  logic                 r_step;
  logic                 r_err;
  logic                 r_up_dn;
  logic [ERR_CNT_W-1:0] r_err_count;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (enc_a),
    .dout   (w_filt_a)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (enc_b),
    .dout   (w_filt_b)
  );

  assign w_curr_ab = {w_filt_a, w_filt_b};

  always_comb begin
    w_step_d  = 1'b0;
    w_err_d   = 1'b0;
    w_up_dn_d = r_up_dn;
    if (is_illegal(r_prev_ab, w_curr_ab)) begin
      w_err_d = 1'b1;
    end else if (r_prev_ab != w_curr_ab) begin
`ifdef QUAD_X4_EN
      w_step_d  = 1'b1;
      w_up_dn_d = is_up(r_prev_ab, w_curr_ab) ? DIR_UP : DIR_DN;
`else
      if (w_curr_ab == ST_00) begin
        w_step_d  = 1'b1;
        w_up_dn_d = (r_prev_ab == ST_01) ? DIR_UP : DIR_DN;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_ab   <= ST_00;
      r_step      <= 1'b0;
      r_err       <= 1'b0;
      r_up_dn     <= DIR_UP;
      r_err_count <= '0;
    end else begin
      r_prev_ab <= w_curr_ab;
      r_step    <= w_step_d;
      r_err     <= w_err_d;
      r_up_dn   <= w_up_dn_d;
      if (w_err_d && (r_err_count != ErrCntMax)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign step      = r_step;
  assign err       = r_err;
  assign up_dn     = r_up_dn;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder (DEBOUNCE_CYCLES=4, ERR_CNT_W=3), x1 or x4 build.
module tb_quad_step_decoder;

`ifdef QUAD_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif
  localparam int LAT = 7;  // pin change to strobe: 3 + DEBOUNCE_CYCLES

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       step;
  logic       up_dn;
  logic       err;
  logic [2:0] err_count;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct {
    int   kind;  // 1 = step, 2 = err
    int   at;
    logic dir;
    int   cnt;
  } exp_t;
  exp_t q[$];

  logic last_dir = 1'b1;
  int   exp_cnt  = 0;

  quad_step_decoder #(.DEBOUNCE_CYCLES(4), .ERR_CNT_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .step     (step),
    .up_dn    (up_dn),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // kind: 0 = nothing expected, 1 = step with direction dir, 2 = err
  task automatic drive(input logic [1:0] ab, input int kind, input logic dir);
    exp_t e;
    @(posedge clk);
    #1;
    {enc_a, enc_b} = ab;
    if (kind == 1) begin
      last_dir = dir;
      e = '{kind: 1, at: cyc + LAT, dir: dir, cnt: exp_cnt};
      q.push_back(e);
    end else if (kind == 2) begin
      if (exp_cnt < 7) exp_cnt++;
      e = '{kind: 2, at: cyc + LAT, dir: last_dir, cnt: exp_cnt};
      q.push_back(e);
    end
    repeat (9) @(posedge clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (step || err) begin
      check("step_err_exclusive", int'(step & err), 0);
      if (q.size() == 0) begin
        check("unexpected_strobe", int'({err, step}), 0);
      end else begin
        e = q.pop_front();
        check("strobe_kind", step ? 1 : 2, e.kind);
        check("strobe_cycle", cyc, e.at);
        check("strobe_up_dn", int'(up_dn), int'(e.dir));
        check("strobe_err_count", int'(err_count), e.cnt);
      end
    end
  end

  initial begin
    // 1. reset and idle
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_step", int'(step), 0);
    check("idle_err", int'(err), 0);
    check("idle_up_dn", int'(up_dn), 1);
    check("idle_err_count", int'(err_count), 0);

    // 2. up sequence
    drive(2'b10, X4 ? 1 : 0, 1'b1);
    drive(2'b11, X4 ? 1 : 0, 1'b1);
    drive(2'b01, X4 ? 1 : 0, 1'b1);
    drive(2'b00, 1, 1'b1);
    check("after_up_dir", int'(up_dn), 1);

    // 3. down sequence
    drive(2'b01, X4 ? 1 : 0, 1'b0);
    drive(2'b11, X4 ? 1 : 0, 1'b0);
    drive(2'b10, X4 ? 1 : 0, 1'b0);
    drive(2'b00, 1, 1'b0);
    check("after_down_dir", int'(up_dn), 0);

    // 4. short glitch on A
    @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 enc_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_filt_a", int'(dut.u_deb_a.dout), 0);
    check("glitch_up_dn", int'(up_dn), 0);

    // 5. double-bit changes, then saturation
    drive(2'b11, 2, 1'b0);
    check("err_count_one", int'(err_count), 1);
    check("err_up_dn_kept", int'(up_dn), 0);
    for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 2'b00 : 2'b11, 2, 1'b0);
    drive(2'b00, 2, 1'b0);
    check("err_count_sat", int'(err_count), 7);

    // 6. reset while A's debounce count sits at 2
    @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_cnt", int'(dut.u_deb_a.r_cnt), 2);
    reset_n = 1'b0;
    #1;
    check("rst_step", int'(step), 0);
    check("rst_err", int'(err), 0);
    check("rst_up_dn", int'(up_dn), 1);
    check("rst_err_count", int'(err_count), 0);
    check("rst_filt_a", int'(dut.u_deb_a.dout), 0);
    last_dir = 1'b1;
    exp_cnt  = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    if (X4) q.push_back('{kind: 1, at: cyc + LAT, dir: 1'b1, cnt: 0});
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_filt_early", int'(dut.u_deb_a.dout), 0);
    repeat (5) @(posedge clk);
    drive(2'b00, 1, 1'b0);
    check("post_reset_err_count", int'(err_count), 0);

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
